// File: rtl/ram_resp.sv
// ram_resp: byte-wide RAM responder serving 8-beat line bursts paced by rack
//   ram_clk       : clock, rising edge
//   reset         : asynchronous, active-low
//   avalid        : request valid, held high by the initiator for the whole burst
//   rnw, raddr    : direction and line address, captured with the request
//   rwdata        : write byte, sampled at the edge ending each rack-high cycle
//   rrdata        : read byte, registered on entry to each read beat
//   rack          : registered beat strobe, one cycle per beat
module ram_resp #(
  parameter int ADDR_W  = 13,
  parameter int LATENCY = 2
) (
  input  logic              ram_clk,
  input  logic              reset,
  input  logic              avalid,
  input  logic              rnw,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [7:0]        rwdata,
  output logic [7:0]        rrdata,
  output logic              rack
);
  typedef enum logic [2:0] {IDLE, WAIT, BEAT, GAP, DONE} state_t;
  state_t            r_state, w_next;
  logic [3:0]        r_cnt, w_cnt;
  logic [2:0]        r_beat, w_beat;
  logic [ADDR_W-1:0] r_line, w_line;
  logic              r_dir, w_dir;
  logic              w_we;
  logic              r_rack;
  logic [7:0]        r_rrdata;
  // Power-up contents are zero; reset never touches the array.
  logic [7:0]        r_mem [2**(ADDR_W+3)] = '{default: 8'h00};
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    w_beat = r_beat;
    w_line = r_line;
    w_dir  = r_dir;
    w_we   = 1'b0;
    case (r_state)
      IDLE: if (avalid) begin
        w_line = raddr;
        w_dir  = rnw;
        w_beat = 3'd0;
        w_cnt  = (LATENCY == 0) ? r_cnt : 4'(LATENCY);
        w_next = (LATENCY == 0) ? BEAT : WAIT;
      end
      WAIT: begin
        w_cnt  = r_cnt - 4'd1;
        w_next = !avalid ? IDLE : (r_cnt == 4'd1) ? BEAT : WAIT;
      end
      // An aborted beat is dropped without writing.
      BEAT: if (!avalid) w_next = IDLE;
      else begin
        w_we   = !r_dir;
        w_next = (r_beat == 3'd7) ? DONE : GAP;
        w_beat = (r_beat == 3'd7) ? r_beat : r_beat + 3'd1;
      end
      GAP:  w_next = avalid ? BEAT : IDLE;
      DONE: w_next = avalid ? DONE : IDLE;
      default: w_next = IDLE;
    endcase
  end
  // rack and rrdata are computed from the next state so they line up with BEAT.
  always_ff @(posedge ram_clk or negedge reset)
    if (!reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_beat   <= 3'd0;
      r_line   <= '0;
      r_dir    <= 1'b0;
      r_rack   <= 1'b0;
      r_rrdata <= 8'h00;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_beat  <= w_beat;
      r_line  <= w_line;
      r_dir   <= w_dir;
      r_rack  <= w_next == BEAT;
      if (w_next == BEAT && w_dir) r_rrdata <= r_mem[{w_line, w_beat}];
    end
  always_ff @(posedge ram_clk)
    if (w_we) r_mem[{r_line, r_beat}] <= rwdata;
  assign rack   = r_rack;
  assign rrdata = r_rrdata;
endmodule

// File: tb/tb_ram_resp.sv
// tb_ram_resp: table-driven and randomized bench for ram_resp at LATENCY 2 and 0
module tb_ram_resp;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  av = 2'b00;
  logic        rnw = 1'b0;
  logic [12:0] raddr = '0;
  logic [7:0]  rwdata = '0;
  logic [7:0]  rd2, rd0;
  logic        rk2, rk0;
  int          n_chk = 0, n_err = 0;
  logic [7:0]  mm [2][65536];
  logic [7:0]  last_rd [2];
  typedef struct {
    int          s;
    logic [12:0] a;
    bit          rd;
    logic [63:0] wd;
    int          ab;
    int          hold;
    logic [63:0] exp;
  } vec_t;
  vec_t tbl[$];
  always #5 clk = ~clk;
  ram_resp #(.ADDR_W(13), .LATENCY(2)) u_l2 (
    .ram_clk(clk), .reset(reset), .avalid(av[0]), .rnw(rnw), .raddr(raddr),
    .rwdata(rwdata), .rrdata(rd2), .rack(rk2));
  ram_resp #(.ADDR_W(13), .LATENCY(0)) u_l0 (
    .ram_clk(clk), .reset(reset), .avalid(av[1]), .rnw(rnw), .raddr(raddr),
    .rwdata(rwdata), .rrdata(rd0), .rack(rk0));
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask
  // One request on instance s (0: LATENCY 2, 1: LATENCY 0); ab = cycle at whose
  // negedge avalid drops (-1 none); hold = extra cycles avalid stays high after DONE.
  task automatic burst(input int s, input logic [12:0] a, input bit rd, input logic [63:0] wd,
                       input int ab, input int hold, output logic [63:0] got);
    int L, ae, k;
    bit er;
    logic [63:0] exp;
    L = (s == 1) ? 0 : 2;
    ae = (ab < 0) ? 1000 : ab;
    got = '0;
    for (int b = 0; b < 8; b++) exp[8*b +: 8] = mm[s][{a, 3'(b)}];
    @(negedge clk);
    raddr = a;
    rnw = rd;
    av[s] = 1'b1;
    @(negedge clk);
    for (int t = 0; t < L + 16; t++) begin
      k = (t >= L) ? (t - L) / 2 : 0;
      er = t <= ae && t >= L && ((t - L) % 2) == 0 && k < 8;
      chk("rack", s ? rk0 : rk2, er);
      if (er && rd) begin
        last_rd[s] = exp[8*k +: 8];
        got[8*k +: 8] = s ? rd0 : rd2;
      end
      chk("rrdata", s ? rd0 : rd2, last_rd[s]);
      if (er && !rd && L + 2 * k < ae) mm[s][{a, 3'(k)}] = wd[8*k +: 8];
      raddr = a - 13'd1;
      rnw = ~rd;
      rwdata = er ? wd[8*k +: 8] : 8'($urandom);
      if (t == ae) av[s] = 1'b0;
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      chk("rack_held", s ? rk0 : rk2, 1'b0);
      @(negedge clk);
    end
    av[s] = 1'b0;
    @(negedge clk);
    chk("rack_idle", s ? rk0 : rk2, 1'b0);
  endtask
  // Reset asserted at the negedge of cycle tr of a LATENCY-2 burst.
  task automatic reset_mid(input logic [12:0] a, input bit rd, input logic [63:0] wd, input int tr);
    @(negedge clk);
    raddr = a;
    rnw = rd;
    av[0] = 1'b1;
    @(negedge clk);
    for (int t = 0; t < tr; t++) begin
      if (t >= 2 && ((t - 2) % 2) == 0) begin
        rwdata = wd[8*((t-2)/2) +: 8];
        if (!rd) mm[0][{a, 3'((t-2)/2)}] = rwdata;
      end
      @(negedge clk);
    end
    reset = 1'b0;
    #1;
    chk("rst_rack", rk2, 1'b0);
    chk("rst_rrdata2", rd2, 8'h00);
    chk("rst_rrdata0", rd0, 8'h00);
    av[0] = 1'b0;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    @(negedge clk);
    reset = 1'b1;
  endtask
  initial begin
    logic [63:0] got;
    logic [12:0] pool [4] = '{13'h0A5, 13'h1FFF, 13'h0002, 13'h0005};
    foreach (mm[i, j]) mm[i][j] = 8'h00;
    last_rd[0] = 8'h00;
    last_rd[1] = 8'h00;
    tbl.push_back('{0, 13'h0A5,  1'b0, 64'h8877665544332211, -1, 0,  64'h0});
    tbl.push_back('{0, 13'h0A5,  1'b1, 64'h0,                -1, 0,  64'h8877665544332211});
    tbl.push_back('{0, 13'h1FFF, 1'b0, 64'h5555555555555555, -1, 0,  64'h0});
    tbl.push_back('{0, 13'h1FFF, 1'b0, 64'hB1B0AFAEADACABAA,  7, 0,  64'h0});
    tbl.push_back('{0, 13'h1FFF, 1'b1, 64'h0,                -1, 0,  64'h5555555555ACABAA});
    tbl.push_back('{0, 13'h0001, 1'b0, 64'h0101010101010101, -1, 0,  64'h0});
    tbl.push_back('{0, 13'h0002, 1'b0, 64'h0202020202020202, -1, 0,  64'h0});
    tbl.push_back('{0, 13'h0002, 1'b1, 64'h0,                -1, 0,  64'h0202020202020202});
    tbl.push_back('{0, 13'h0A5,  1'b1, 64'h0,                -1, 40, 64'h8877665544332211});
    tbl.push_back('{0, 13'h0A5,  1'b0, 64'h0,                 0, 0,  64'h0});
    tbl.push_back('{0, 13'h0A5,  1'b1, 64'h0,                -1, 0,  64'h8877665544332211});
    tbl.push_back('{1, 13'h0005, 1'b0, 64'hF0E0D0C0B0A09080, -1, 0,  64'h0});
    tbl.push_back('{1, 13'h0005, 1'b1, 64'h0,                -1, 0,  64'hF0E0D0C0B0A09080});
    tbl.push_back('{1, 13'h0005, 1'b0, 64'h1111111111111111,  2, 0,  64'h0});
    tbl.push_back('{1, 13'h0005, 1'b1, 64'h0,                -1, 0,  64'hF0E0D0C0B0A09011});
    repeat (2) @(negedge clk);
    chk("init_rack2", rk2, 1'b0);
    chk("init_rack0", rk0, 1'b0);
    chk("init_rrdata2", rd2, 8'h00);
    chk("init_rrdata0", rd0, 8'h00);
    reset = 1'b1;
    foreach (tbl[i]) begin
      burst(tbl[i].s, tbl[i].a, tbl[i].rd, tbl[i].wd, tbl[i].ab, tbl[i].hold, got);
      if (tbl[i].rd) chk($sformatf("vec%0d", i), got, tbl[i].exp);
    end
    reset_mid(13'h0A5, 1'b1, 64'h0, 1);
    burst(0, 13'h0000, 1'b1, 64'h0, -1, 0, got);
    chk("line0_zero", got, 64'h0);
    reset_mid(13'h0A5, 1'b0, 64'hFFFFFFFFFFFFFFFF, 4);
    burst(0, 13'h0A5, 1'b1, 64'h0, -1, 0, got);
    chk("rst_partial_write", got, 64'h88776655443322FF);
    for (int i = 0; i < 40; i++) begin
      int s, ab;
      logic [12:0] a;
      s = $urandom_range(0, 1);
      a = ($urandom_range(0, 4) == 4) ? 13'($urandom) : pool[$urandom_range(0, 3)];
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 17) : -1;
      burst(s, a, 1'($urandom), {$urandom, $urandom}, ab, $urandom_range(0, 3), got);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/ram_resp.md
# ram_resp

Byte-wide RAM responder for the cache's RAM-side interface, in the `ram_clk` domain. It accepts line requests (`avalid`, `raddr`, `rnw`) from the cache's RAM interface and serves each as an 8-beat byte burst, paced with `rack` pulses, against an internal byte array. It serves as the system-side external memory model and as the bench reference for the cache's refill and write-back paths.

## Interface
Parameters:
- `ADDR_W`, 13, line-address width; array depth is 2^ADDR_W lines × 8 bytes.
- `LATENCY`, 2, wait cycles between request capture and the first beat (0..15).

Ports:
- `ram_clk` in 1: single clock, all logic on the rising edge.
- `reset` in 1: asynchronous, active-low.
- `avalid` in 1: request valid; held high by the initiator for the whole burst.
- `rnw` in 1: 1 = read line, 0 = write line; sampled with the request.
- `raddr` in ADDR_W: line address; sampled with the request.
- `rwdata` in 8: write byte for the current beat.
- `rrdata` out 8: read byte for the current beat.
- `rack` out 1: beat strobe, high for exactly one cycle per beat.

## Operation
- Byte address = {line_addr, beat[2:0]}. Beat 0 is the lowest byte, i.e. line bits [7:0].
- FSM states: IDLE, WAIT, BEAT, GAP, DONE.
- IDLE: on an edge with `avalid`=1, latch `raddr`→line_addr and `rnw`→dir, and clear beat to 0.
  - If `LATENCY`=0, go to BEAT. Otherwise load cnt=LATENCY and go to WAIT.
- WAIT: cnt decrements each edge. Leave for BEAT on the edge where cnt==1.
- BEAT: `rack`=1.
  - On read, `rrdata` holds mem[{line_addr,beat}], registered on entry to BEAT.
  - On the exit edge of a write burst, mem[{line_addr,beat}] ← `rwdata`.
  - Exit: if beat==7 go to DONE; otherwise beat+1 and go to GAP.
- GAP: `rack`=0; go to BEAT next edge. The gap lets the initiator advance `rwdata` or consume `rrdata`.
- DONE: `rack`=0. Go to IDLE on the first edge with `avalid`=0, so a held `avalid` never retriggers.
- `raddr`, `rnw` and `rwdata` outside the capture points are ignored. Address changes mid-burst have no effect.
- Abort: `avalid` sampled 0 in WAIT, BEAT or GAP → IDLE at that edge, with `rack`=0 from the next cycle.
  - Write beats already committed remain in memory. The beat being aborted in BEAT is not written.
- `rrdata` updates only on entry to a read beat. It holds its value otherwise, including across write bursts.
- Memory is never cleared by reset. Contents at time zero are all zero (initialised array).

## Timing
- Reset (asynchronous, immediate): state=IDLE, `rack`=0, `rrdata`=8'h00, beat=0, cnt=0. Memory is unchanged.
- Reset mid-burst: the burst is dropped, and any beat not yet at its exit edge is not written.
- Request captured at edge E0 → `rack` is high from edge E0+LATENCY+2k to E0+LATENCY+2k+1, for k=0..7.
- Last `rack` falls at E0+LATENCY+15. Minimum request-to-request spacing is LATENCY+17 edges, including one cycle with `avalid` low.
- Read data: `rrdata` is valid in the same cycle `rack` is high, and stable until the next beat entry.
- Write data: `rwdata` must be stable at the edge ending each `rack`-high cycle.
- `rack` and `rrdata` are registered outputs, with no combinational path from inputs.

## Test plan
- Reset: assert `reset`=0 mid-WAIT → `rack`=0, `rrdata`=00 immediately. After release, a read of line 0 returns 00×8.
- Write then read, LATENCY=2: write line 13'h0A5 with bytes 11,22,...,88. Read line 13'h0A5 → `rrdata` sequence 11,22,33,44,55,66,77,88.
  - First `rack` at E0+2, pulses at every second edge, exactly 8 pulses.
- LATENCY=0: read request → `rack` high in the cycle right after the capture edge. Beat spacing is 2 cycles.
- Held `avalid`: keep `avalid`=1 for 40 cycles after one burst → exactly 8 `rack` pulses, no second burst.
  - Dropping then re-raising `avalid` starts a new burst.
- Abort: write line 13'h1FFF (highest line address) with AA..., and drop `avalid` after the 3rd `rack` → bytes 0–2 = AA,AB,AC. Bytes 3–7 keep their prior values.
- Address change mid-burst: change `raddr` to 13'h0001 after beat 0 of a read of 13'h0002 → all 8 bytes come from line 0002.
